// File: rtl/dummy_accelerator_varlat.sv
// Coprocessor datapath with per-instruction latency taken from the immediate.
// Results are held in a DEPTH-entry in-flight buffer and retire strictly in order.
module dummy_accelerator_varlat #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned IMM_WIDTH   = 11,
    parameter type         TagType_t   = logic,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned MAX_LATENCY = 100
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [1:0]                 op_i,
    input  logic [WIDTH-1:0]           rs1_value_i,
    input  logic [IMM_WIDTH-1:0]       imm_i,
    input  TagType_t                   tag_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WIDTH-1:0]           result_o,
    output TagType_t                   tag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = $clog2(DEPTH + 1);
    localparam int unsigned CntW   = $clog2(MAX_LATENCY + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CntW-1:0]  cnt_q    [DEPTH];
    logic [CntW-1:0]  cnt_d    [DEPTH];
    logic [WIDTH-1:0] result_q [DEPTH];
    logic [WIDTH-1:0] result_d [DEPTH];
    TagType_t         tag_q    [DEPTH];
    TagType_t         tag_d    [DEPTH];

    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [CountW-1:0] count_q, count_d;

    logic             push, pop;
    logic [31:0]      imm_ext;
    logic [CntW-1:0]  lat_m1;
    logic [WIDTH-1:0] op_result;

    assign ready_o = (count_q != CountW'(DEPTH));
    assign count_o = count_q;
    assign valid_o = valid_q[rptr_q] && (cnt_q[rptr_q] == '0);
    assign result_o = valid_o ? result_q[rptr_q] : '0;
    assign tag_o    = valid_o ? tag_q[rptr_q] : '0;

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    assign imm_ext = 32'(imm_i);

    // Countdown is loaded with L-1; L is the immediate clamped to [1, MAX_LATENCY].
    always_comb begin
        if (imm_ext == 32'd0) begin
            lat_m1 = '0;
        end else if (imm_ext > 32'(MAX_LATENCY)) begin
            lat_m1 = CntW'(MAX_LATENCY - 1);
        end else begin
            lat_m1 = CntW'(imm_ext - 32'd1);
        end
    end

    always_comb begin
        op_result = rs1_value_i;
        unique case (op_i)
            2'b00: op_result = rs1_value_i ^ WIDTH'(imm_i);
            2'b01: op_result = rs1_value_i + WIDTH'(imm_i);
            2'b10: op_result = rs1_value_i;
            2'b11: op_result = ~rs1_value_i;
        endcase
    end

    always_comb begin
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        tag_d    = tag_q;
        rptr_d   = rptr_q;
        wptr_d   = wptr_q;
        count_d  = count_q;

        if (flush_i) begin
            valid_d = '0;
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            // Every entry counts down independently of head position or backpressure.
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (cnt_q[i] != '0)) begin
                    cnt_d[i] = cnt_q[i] - CntW'(1);
                end
            end
            if (pop) begin
                valid_d[rptr_q] = 1'b0;
                rptr_d          = rptr_q + PtrW'(1);
            end
            if (push) begin
                valid_d[wptr_q]  = 1'b1;
                cnt_d[wptr_q]    = lat_m1;
                result_d[wptr_q] = op_result;
                tag_d[wptr_q]    = tag_i;
                wptr_d           = wptr_q + PtrW'(1);
            end
            count_d = count_q + CountW'(push) - CountW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i]    <= '0;
                result_q[i] <= '0;
                tag_q[i]    <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            tag_q    <= tag_d;
        end
    end

endmodule

// File: tb/tb_dummy_accelerator_varlat.sv
// Scoreboard bench for dummy_accelerator_varlat: directed pushes queue expected results,
// a negedge monitor compares every presented result, its tag and its first-valid cycle.
module tb_dummy_accelerator_varlat;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        int          cyc;
        bit          exact;
    } exp_t;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  op_i;
    logic [31:0] rs1_value_i;
    logic [10:0] imm_i;
    logic [3:0]  tag_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [3:0]  tag_o;
    logic [2:0]  count_o;

    exp_t sb[$];
    bit   seen = 0;
    int   cyc = 0;
    int   last_exp = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    dummy_accelerator_varlat #(
        .WIDTH      (32),
        .IMM_WIDTH  (11),
        .TagType_t  (logic [3:0]),
        .DEPTH      (4),
        .MAX_LATENCY(100)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .op_i       (op_i),
        .rs1_value_i(rs1_value_i),
        .imm_i      (imm_i),
        .tag_i      (tag_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o),
        .tag_o      (tag_o),
        .count_o    (count_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard head.
    always @(negedge clk_i) begin
        if (valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", valid_o, 0);
            end else begin
                check("result", result_o, sb[0].res);
                check("tag", tag_o, sb[0].tag);
                if (!seen) begin
                    seen = 1;
                    if (sb[0].exact) check("retire_cycle", cyc, sb[0].cyc);
                    else check("not_early", cyc >= sb[0].cyc, 1);
                end
                if (ready_i) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end else begin
            check("result_gated", result_o, 0);
            check("tag_gated", tag_o, 0);
        end
    end

    task automatic push(input logic [1:0] op, input logic [31:0] rs1, input logic [10:0] imm,
                        input logic [3:0] tag, input logic [31:0] res, input int lat,
                        input bit exact);
        int a;
        int e;
        int guard;
        valid_i     = 1'b1;
        op_i        = op;
        rs1_value_i = rs1;
        imm_i       = imm;
        tag_i       = tag;
        @(negedge clk_i);
        guard = 0;
        while (!ready_o && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        if (!ready_o) begin
            check("push_ready_timeout", ready_o, 1);
            valid_i = 1'b0;
            return;
        end
        a = cyc + 1;
        e = a + lat - 1;
        if (e <= last_exp) e = last_exp + 1;
        last_exp = e;
        sb.push_back('{res: res, tag: tag, cyc: e, exact: exact});
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        valid_i     = 1'b0;
        ready_i     = 1'b1;
        op_i        = '0;
        rs1_value_i = '0;
        imm_i       = '0;
        tag_i       = '0;
        #12;
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_count", count_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single op and boundary latencies.
        push(2'b00, 32'h0000_00F0, 11'd3, 4'd1, 32'h0000_00F3, 3, 1);
        wait_drain(20);
        check("single_count", count_o, 0);
        push(2'b10, 32'h1234_5678, 11'd0, 4'd2, 32'h1234_5678, 1, 1);
        wait_drain(20);
        push(2'b11, 32'h0F0F_0F0F, 11'd2000, 4'd3, 32'hF0F0_F0F0, 100, 1);
        wait_drain(300);
        push(2'b01, 32'hFFFF_FFFF, 11'd1, 4'd4, 32'h0000_0000, 1, 1);
        wait_drain(20);

        // Mixed latency: the short second op must wait behind the first.
        push(2'b00, 32'h0000_0000, 11'd5, 4'd5, 32'h0000_0005, 5, 1);
        push(2'b10, 32'h0000_ABCD, 11'd1, 4'd6, 32'h0000_ABCD, 1, 1);
        wait_drain(30);

        // Backpressure until full, then drain one per cycle.
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(2'b10, 32'hA0 + i, 11'd1, 4'(8 + i), 32'hA0 + i, 1, 0);
        end
        check("full_ready", ready_o, 0);
        check("full_count", count_o, 4);
        check("full_valid", valid_o, 1);
        repeat (3) @(posedge clk_i);
        #1;
        check("held_count", count_o, 4);
        ready_i = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            @(posedge clk_i);
            #1;
            check("drain_count", count_o, 3'(i));
            check("drain_ready", ready_o, 1);
        end
        check("drain_done", sb.size(), 0);

        // Flush with in-flight entries; the same-cycle push must be dropped.
        for (int i = 0; i < 3; i++) begin
            push(2'b00, 32'h100, 11'd10, 4'(1 + i), 32'h10A, 10, 0);
        end
        check("pre_flush_count", count_o, 3);
        sb.delete();
        seen        = 0;
        flush_i     = 1'b1;
        valid_i     = 1'b1;
        op_i        = 2'b10;
        rs1_value_i = 32'h55;
        imm_i       = 11'd1;
        tag_i       = 4'd15;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush_count", count_o, 0);
        check("flush_valid", valid_o, 0);
        check("flush_ready", ready_o, 1);
        repeat (20) @(posedge clk_i);
        #1;
        check("post_flush_count", count_o, 0);

        // Asynchronous reset between edges with two entries pending.
        ready_i = 1'b0;
        push(2'b10, 32'hCAFE_0001, 11'd1, 4'd12, 32'hCAFE_0001, 1, 0);
        push(2'b00, 32'h0000_0000, 11'd10, 4'd13, 32'h0000_000A, 10, 0);
        #2;
        check("pre_rst_valid", valid_o, 1);
        check("pre_rst_count", count_o, 2);
        rst_ni = 1'b0;
        sb.delete();
        seen = 0;
        #1;
        check("async_rst_valid", valid_o, 0);
        check("async_rst_ready", ready_o, 1);
        check("async_rst_count", count_o, 0);
        check("async_rst_result", result_o, 0);
        check("async_rst_tag", tag_o, 0);
        #20;
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        check("post_rst_count", count_o, 0);

        // Operation after reset: add with saturated latency.
        push(2'b01, 32'h0000_0010, 11'd2047, 4'd7, 32'h0000_080F, 100, 1);
        wait_drain(300);
        check("final_count", count_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dummy_accelerator_varlat.md
Name: dummy_accelerator_varlat

Overview:
- Next-generation dummy coprocessor datapath with a per-instruction latency taken from the immediate.
- Consecutive instructions may carry different latencies; results always retire in order.
- Adds selectable operation modes, a DEPTH-entry in-flight buffer with occupancy reporting, and clean backpressure.
- Sits behind the X-interface adapter, the same slot as the current dummy accelerator pipeline.

Parameters:
WIDTH, 32, data width of operands and result
IMM_WIDTH, 11, immediate width; IMM_WIDTH <= WIDTH
TagType_t, logic, opaque tag type carried with each instruction (rd/id)
DEPTH, 4, in-flight entries; power of two, >= 2
MAX_LATENCY, 100, latency saturation value in cycles; >= 1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush; discards all in-flight entries
valid_i  in  1  upstream instruction valid
ready_o  out  1  block can accept an instruction
op_i  in  2  operation select
rs1_value_i  in  WIDTH  source operand
imm_i  in  IMM_WIDTH  immediate; also the requested latency
tag_i  in  TagType_t  instruction tag
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
result_o  out  WIDTH  result
tag_o  out  TagType_t  tag of the retiring instruction
count_o  out  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Clock/reset: single clock clk_i; reset is asynchronous, active-low (rst_ni).
- Reset values: valid_o=0, ready_o=1, result_o='0, tag_o='0, count_o=0; all entries invalid, read and write pointers 0.
- Accept: an instruction is accepted on a rising edge where valid_i && ready_o.
- ready_o = (count_o != DEPTH). It is registered-state only; there is no combinational path from ready_i or valid_i.
  - When full, a same-cycle pop does not enable a same-cycle push.
- Result is computed combinationally at accept and stored in the entry:
  - op 00: rs1 XOR zero-extended imm
  - op 01: (rs1 + zero-extended imm) mod 2^WIDTH
  - op 10: rs1
  - op 11: bitwise NOT rs1
- Latency: L = 1 if imm==0; L = MAX_LATENCY if imm > MAX_LATENCY; otherwise L = imm.
  - At accept, the entry countdown is loaded with L-1.
  - Every subsequent edge, each valid entry with countdown>0 decrements by 1. Countdown continues regardless of ready_i or head position.
- Retire: valid_o = head entry valid && head countdown==0.
  - An instruction accepted at edge t presents valid_o no earlier than the cycle after edge t+L-1, i.e. L cycles after the accept cycle.
  - Retirement happens on an edge with valid_o && ready_i: head invalidated, read pointer advances with wrap-around at DEPTH.
- In-order: a younger entry whose countdown has reached 0 waits behind an older head; it then retires on the cycle immediately following the head's retirement (zero bubble).
- Backpressure: while valid_o && !ready_i, valid_o, result_o and tag_o are held stable.
- Output gating: result_o and tag_o are driven to '0 whenever valid_o=0.
- Simultaneous push and pop when not full: both occur and count_o is unchanged.
- Pointers: write pointer wraps at DEPTH. Pointers are $clog2(DEPTH) bits; full/empty is derived from the occupancy counter.
- Flush: on an edge with flush_i=1, all entries are invalidated, pointers and count are cleared, and the valid_i/ready_i handshakes of that cycle are ignored. Next cycle: valid_o=0, ready_o=1.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no result from before reset is ever emitted.

Test Plan:
- Single op: op=00, rs1=0x0000_00F0, imm=3, tag=1; ready_i=1 → valid_o exactly 3 cycles after accept, result_o=0x0000_00F3, tag_o=1, then count_o=0.
- Zero and saturation: imm=0 → valid_o 1 cycle after accept. imm=2000 with MAX_LATENCY=100 → valid_o exactly 100 cycles after accept. op=01, rs1=0xFFFF_FFFF, imm=1 → result 0x0000_0000.
- Mixed latency in order: back-to-back accepts tag A (imm=5) then tag B (imm=1) → A retires at +5, B at +6 relative to A's accept; never B before A.
- Backpressure/full: DEPTH=4, ready_i=0, push 4 ops with imm=1 → ready_o=0 after the 4th accept, count_o=4, valid_o held with stable result/tag. Raise ready_i → 4 consecutive retirements in order; ready_o=1 after the first pop.
- Flush: 3 entries in flight with imm=10, assert flush_i 1 cycle → next cycle count_o=0, valid_o=0, ready_o=1; no result emitted within 20 cycles.
- Async reset mid-op: drop rst_ni between clock edges with 2 entries pending → outputs at reset values immediately; after release, no stale valid_o.
